mul_arbiter: RTL and testbench
==============================

# mul_arbiter

Round-robin controller sharing one signed fixed-point `multiplier` instance between `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, registers its operands and sequences the multiplier through a full clock period. It then returns the scaled product on a single response port tagged with the requester index. It sits between the datapath units, such as filter taps and gain stages, and the one area-expensive multiplier.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `A_WIDTH`, default 16: operand A width, signed.
- `B_WIDTH`, default 16: operand B width, signed.
- `OUT_WIDTH`, default 32: product width passed to the multiplier.
- `OUT_SCALE`, default 16: arithmetic right shift applied by the multiplier.
- `ID_W`: localparam, `$clog2(NUM_REQ)`.
- `clk` in 1: the single clock; rising edge.
- `arst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: bit i set means requester i presents operands.
- `req_ready` out NUM_REQ: one-hot or zero; bit i set means requester i's operands are taken this cycle.
- `req_a` in NUM_REQ*A_WIDTH: requester i occupies slice [i*A_WIDTH +: A_WIDTH].
- `req_b` in NUM_REQ*B_WIDTH: requester i occupies slice [i*B_WIDTH +: B_WIDTH].
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out ID_W: index of the requester that owns `rsp_data`.
- `rsp_data` out OUT_WIDTH: signed result, equal to (a*b)>>>OUT_SCALE.
- `perf_busy_cnt` out 32: present only with `MUL_ARB_PERF_CNT_EN`.

## Operation
- The FSM has three states: IDLE, EXEC and RESP. Reset state is IDLE.
- **IDLE:**
  - If any `req_valid` is set, select grant g by round-robin and assert `req_ready[g]` combinationally.
  - Latch `req_a[g]`, `req_b[g]` and g into the operand registers, then go to EXEC.
  - If no `req_valid` is set, stay in IDLE.
- **EXEC:** operand registers drive the multiplier. At the end of the cycle, latch the multiplier output into `rsp_data` and the id into `rsp_id`, then go to RESP. `req_ready` is 0.
- **RESP:** `rsp_valid` is 1. `rsp_data` and `rsp_id` hold stable until the handshake completes.
  - If `rsp_ready` is set and any `req_valid` is set, perform the IDLE grant in the same cycle and go to EXEC (back-to-back).
  - If `rsp_ready` is set and no `req_valid` is set, go to IDLE.
  - If `rsp_ready` is 0, stay in RESP and keep `req_ready` at 0.
- **Round-robin:**
  - Pointer `rr_ptr` resets to 0.
  - Search starts at `rr_ptr` and wraps through NUM_REQ-1 to 0; the first set `req_valid` wins.
  - On each grant, `rr_ptr` becomes (g+1) mod NUM_REQ.
  - Requesters that are not granted keep waiting. A requester may drop `req_valid` before its grant; nothing of it is captured.
- **Arithmetic:**
  - Full signed product of width A_WIDTH+B_WIDTH.
  - Arithmetic shift right by OUT_SCALE.
  - Truncate to OUT_WIDTH.
  - No saturation.

## Timing
- Reset values:
  - `req_ready` = 0
  - `rsp_valid` = 0
  - `rsp_id` = 0
  - `rsp_data` = 0
  - `rr_ptr` = 0
  - FSM = IDLE
  - `perf_busy_cnt` = 0
- Latency: grant in cycle T, `rsp_valid` high in cycle T+2.
- Throughput: one result per 2 cycles when `rsp_ready` is held high; one per 3 cycles if the FSM passes through IDLE.
- The multiplier path must settle within one clock period; the EXEC state exists to give it a full period. Operands must not change during EXEC.
- Reset asserted mid-operation clears all state immediately and drops the in-flight request and result; there is no response for it.
- Simultaneous `rsp_ready` and new requests in RESP: the response handshake and the new grant occur in the same cycle.

## Configuration
- `MUL_ARB_PERF_CNT_EN` defined:
  - Adds output `perf_busy_cnt`, counting cycles spent in EXEC or RESP.
  - The counter saturates at 32'hFFFF_FFFF and is reset by `arst`.
- Not defined: the port and counter are absent. Functional behaviour is otherwise identical.

## Test plan
- Single request: requester 2 sends a=16'h0100, b=16'h0200, `rsp_ready` is 1 → `req_ready`=4'b0100 in cycle T; `rsp_valid` in T+2 with `rsp_id`=2 and `rsp_data`=32'h0000_0002.
- Signed operand: a=16'hFF00 (-256), b=16'h0200 → `rsp_data`=32'hFFFF_FFFE (-2).
- Fairness: all 4 requesters held valid, `rsp_ready`=1 → grant order 0,1,2,3,0 with a grant every 2 cycles.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, `rsp_data` and `rsp_id` stay stable and `req_ready`=0; on release, the next grant occurs the same cycle.
- Reset mid-EXEC: assert `arst` during EXEC → all outputs are 0 at once; after release, no stale `rsp_valid` appears.
- Perf counter (macro on): 3 back-to-back requests, `rsp_ready`=1 → `perf_busy_cnt`=6 after the last handshake.

Source files
------------

// File: rtl/mul_arbiter.sv
// Round-robin arbiter that shares one signed fixed-point multiplier between NUM_REQ requesters.
// Optional busy-cycle counter output perf_busy_cnt is enabled by defining MUL_ARB_PERF_CNT_EN.

module multiplier #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int OUT_WIDTH = 32,
    parameter int OUT_SCALE = 16
) (
    input  logic signed [A_WIDTH-1:0]   i_a,
    input  logic signed [B_WIDTH-1:0]   i_b,
    output logic signed [OUT_WIDTH-1:0] o_p
);
    localparam int PW = A_WIDTH + B_WIDTH;

    // Widen before shifting so OUT_WIDTH > PW still sees a correctly sign-extended result.
    function automatic logic signed [OUT_WIDTH-1:0] scale_trunc(input logic signed [PW-1:0] prod);
        logic signed [PW+OUT_WIDTH-1:0] ext;
        ext = {{OUT_WIDTH{prod[PW-1]}}, prod};
        return OUT_WIDTH'(ext >>> OUT_SCALE);
    endfunction

    logic signed [PW-1:0] w_a_ext;
    logic signed [PW-1:0] w_b_ext;
    logic signed [PW-1:0] w_prod;

    assign w_a_ext = {{B_WIDTH{i_a[A_WIDTH-1]}}, i_a};
    assign w_b_ext = {{A_WIDTH{i_b[B_WIDTH-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;
    assign o_p     = scale_trunc(w_prod);
endmodule

module mul_arbiter #(
    parameter int  NUM_REQ   = 4,
    parameter int  A_WIDTH   = 16,
    parameter int  B_WIDTH   = 16,
    parameter int  OUT_WIDTH = 32,
    parameter int  OUT_SCALE = 16,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic signed [OUT_WIDTH-1:0]  rsp_data
`ifdef MUL_ARB_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_busy_cnt
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t                      r_state;
    logic [ID_W-1:0]             r_rr_ptr;
    logic signed [A_WIDTH-1:0]   r_op_a_p0;
    logic signed [B_WIDTH-1:0]   r_op_b_p0;
    logic [ID_W-1:0]             r_op_id_p0;
    logic                        r_vld_p1;
    logic [ID_W-1:0]             r_rsp_id_p1;
    logic signed [OUT_WIDTH-1:0] r_rsp_data_p1;

    logic                        w_any;
    logic                        w_take;
    logic [ID_W-1:0]             w_gnt_id;
    logic [ID_W-1:0]             w_rr_next;
    logic signed [A_WIDTH-1:0]   w_sel_a;
    logic signed [B_WIDTH-1:0]   w_sel_b;
    logic signed [OUT_WIDTH-1:0] w_mul_p;

    assign w_any  = |req_valid;
    // A grant is possible from IDLE, or from RESP in the same cycle the response is consumed.
    assign w_take = w_any && ((r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready));

    // Scan downward so the requester closest to r_rr_ptr is assigned last and wins.
    always_comb begin
        w_gnt_id = r_rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            logic [ID_W:0]   sum;
            logic [ID_W-1:0] idx;
            sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ))
                sum = sum - (ID_W+1)'(NUM_REQ);
            idx = sum[ID_W-1:0];
            if (req_valid[idx])
                w_gnt_id = idx;
        end
    end

    assign w_rr_next = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
    assign w_sel_a   = req_a[int'(w_gnt_id)*A_WIDTH +: A_WIDTH];
    assign w_sel_b   = req_b[int'(w_gnt_id)*B_WIDTH +: B_WIDTH];

    always_comb begin
        req_ready = '0;
        if (w_take && !arst)
            req_ready[w_gnt_id] = 1'b1;
    end

    multiplier #(
        .A_WIDTH  (A_WIDTH),
        .B_WIDTH  (B_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .OUT_SCALE(OUT_SCALE)
    ) u_mul (
        .i_a(r_op_a_p0),
        .i_b(r_op_b_p0),
        .o_p(w_mul_p)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_op_a_p0     <= '0;
            r_op_b_p0     <= '0;
            r_op_id_p0    <= '0;
            r_vld_p1      <= 1'b0;
            r_rsp_id_p1   <= '0;
            r_rsp_data_p1 <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take)
                        r_state <= S_EXEC;
                end
                // p0 -> p1: operands held a full period through the multiplier, product captured.
                S_EXEC: begin
                    r_rsp_data_p1 <= w_mul_p;
                    r_rsp_id_p1   <= r_op_id_p0;
                    r_vld_p1      <= 1'b1;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_vld_p1 <= 1'b0;
                        r_state  <= w_take ? S_EXEC : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // grant -> p0: capture the winner's operands and advance the pointer past it.
            if (w_take) begin
                r_op_a_p0  <= w_sel_a;
                r_op_b_p0  <= w_sel_b;
                r_op_id_p0 <= w_gnt_id;
                r_rr_ptr   <= w_rr_next;
            end
        end
    end

    assign rsp_valid = r_vld_p1;
    assign rsp_id    = r_rsp_id_p1;
    assign rsp_data  = r_rsp_data_p1;

`ifdef MUL_ARB_PERF_CNT_EN
    logic [31:0] r_busy_cnt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            r_busy_cnt <= '0;
        else if (((r_state == S_EXEC) || (r_state == S_RESP)) && (r_busy_cnt != 32'hFFFF_FFFF))
            r_busy_cnt <= r_busy_cnt + 32'd1;
    end

    assign perf_busy_cnt = r_busy_cnt;
`endif
endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: expected id/product pushed at grant time, popped when the response is seen.
`timescale 1ns/1ps
module tb_mul_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int BW = 16;
    localparam int OW = 32;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            arst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [OW-1:0]   rsp_data;
`ifdef MUL_ARB_PERF_CNT_EN
    logic [31:0]     perf_busy_cnt;
`endif

    int   n_pass   = 0;
    int   n_checks = 0;
    int   m_rr     = 0;
    exp_t sb_q[$];

    mul_arbiter #(
        .NUM_REQ  (N),
        .A_WIDTH  (AW),
        .B_WIDTH  (BW),
        .OUT_WIDTH(OW),
        .OUT_SCALE(16)
    ) dut (
        .clk      (clk),
        .arst     (arst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data)
`ifdef MUL_ARB_PERF_CNT_EN
        ,
        .perf_busy_cnt(perf_busy_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_mul(logic [15:0] a, logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> 16;
        return p[31:0];
    endfunction

    function automatic int exp_grant(logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic exp_t make_exp(int g);
        exp_t e;
        e.id   = 2'(g);
        e.data = model_mul(req_a[g*AW +: AW], req_b[g*BW +: BW]);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1; req_a = '0; req_b = '0;
        #1;
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b expected 0000", req_ready); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); else n_pass++;
        n_checks++; if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h expected 00000000", rsp_data); else n_pass++;
`ifdef MUL_ARB_PERF_CNT_EN
        n_checks++; if (perf_busy_cnt !== 32'h0) $display("FAIL reset_perf: got %0d expected 0", perf_busy_cnt); else n_pass++;
`endif
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0; req_valid = '0; m_rr = 0; sb_q.delete();
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_idle_valid: got %b expected 0", rsp_valid); else n_pass++;
        tick();
    endtask

    task automatic test_single();
        exp_t e; int g;
        req_a[2*AW +: AW] = 16'h0100; req_b[2*BW +: BW] = 16'h0200;
        req_valid = 4'b0100; rsp_ready = 1'b1;
        @(negedge clk);
        g = exp_grant(req_valid);
        n_checks++; if (req_ready !== 4'b0100) $display("FAIL single_grant: got %b expected 0100", req_ready); else n_pass++;
        sb_q.push_back(make_exp(g)); m_rr = (g + 1) % N;
        tick();
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL single_exec_valid: got %b expected 0", rsp_valid); else n_pass++;
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL single_exec_ready: got %b expected 0000", req_ready); else n_pass++;
        tick();
        @(negedge clk);
        e = sb_q.pop_front();
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); else n_pass++;
        n_checks++; if (rsp_id !== e.id) $display("FAIL single_rsp_id: got %0d expected %0d", rsp_id, e.id); else n_pass++;
        n_checks++; if (rsp_data !== 32'h0000_0002) $display("FAIL single_rsp_data: got %h expected 00000002", rsp_data); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL single_after_hs: got %b expected 0", rsp_valid); else n_pass++;
        tick();
    endtask

    task automatic test_arith();
        int          tid[7] = '{1, 0, 3, 2, 1, 0, 3};
        logic [15:0] ta[7]  = '{16'hFF00, 16'h7FFF, 16'h8000, 16'h8000, 16'h0003, 16'h1234, 16'hC3A1};
        logic [15:0] tb[7]  = '{16'h0200, 16'h7FFF, 16'h8000, 16'h7FFF, 16'hFFFF, 16'hEDCB, 16'h5A5A};
        exp_t e; int g;
        for (int i = 0; i < 7; i++) begin
            req_a[tid[i]*AW +: AW] = ta[i]; req_b[tid[i]*BW +: BW] = tb[i];
            req_valid = 4'(1 << tid[i]);
            @(negedge clk);
            g = exp_grant(req_valid);
            n_checks++; if (req_ready !== 4'(1 << g)) $display("FAIL arith_grant[%0d]: got %b expected %b", i, req_ready, 4'(1 << g)); else n_pass++;
            n_checks++; if (rsp_valid !== 1'b0) $display("FAIL arith_idle_valid[%0d]: got %b expected 0", i, rsp_valid); else n_pass++;
            sb_q.push_back(make_exp(g)); m_rr = (g + 1) % N;
            tick();
            req_valid = '0;
            tick();
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++; if (rsp_valid !== 1'b1) $display("FAIL arith_valid[%0d]: got %b expected 1", i, rsp_valid); else n_pass++;
            n_checks++; if (rsp_id !== e.id) $display("FAIL arith_id[%0d]: got %0d expected %0d", i, rsp_id, e.id); else n_pass++;
            n_checks++; if (rsp_data !== e.data) $display("FAIL arith_data[%0d]: got %h expected %h", i, rsp_data, e.data); else n_pass++;
            if (i == 0) begin
                n_checks++; if (rsp_data !== 32'hFFFF_FFFE) $display("FAIL arith_signed: got %h expected fffffffe", rsp_data); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_fairness();
        exp_t e; int g;
        arst = 1'b1; #2; arst = 1'b0; m_rr = 0; sb_q.delete();
        tick();
        for (int i = 0; i < N; i++) begin
            req_a[i*AW +: AW] = 16'($urandom); req_b[i*BW +: BW] = 16'($urandom);
        end
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c >= 2 && (c % 2) == 0) begin
                e = sb_q.pop_front();
                n_checks++; if (rsp_valid !== 1'b1) $display("FAIL fair_valid[%0d]: got %b expected 1", c, rsp_valid); else n_pass++;
                n_checks++; if (rsp_id !== e.id) $display("FAIL fair_id[%0d]: got %0d expected %0d", c, rsp_id, e.id); else n_pass++;
                n_checks++; if (rsp_data !== e.data) $display("FAIL fair_data[%0d]: got %h expected %h", c, rsp_data, e.data); else n_pass++;
            end
            if ((c % 2) == 0) begin
                g = exp_grant(req_valid);
                n_checks++; if (req_ready !== 4'(1 << g)) $display("FAIL fair_grant[%0d]: got %b expected %b", c, req_ready, 4'(1 << g)); else n_pass++;
                sb_q.push_back(make_exp(g)); m_rr = (g + 1) % N;
            end else begin
                n_checks++; if (req_ready !== 4'b0000) $display("FAIL fair_exec_ready[%0d]: got %b expected 0000", c, req_ready); else n_pass++;
            end
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL fair_last_exec: got %b expected 0", rsp_valid); else n_pass++;
        tick();
        @(negedge clk);
        e = sb_q.pop_front();
        n_checks++; if (rsp_id !== e.id) $display("FAIL fair_last_id: got %0d expected %0d", rsp_id, e.id); else n_pass++;
        n_checks++; if (rsp_data !== e.data) $display("FAIL fair_last_data: got %h expected %h", rsp_data, e.data); else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        exp_t e; int g;
        req_a[3*AW +: AW] = 16'hA5C3; req_b[3*BW +: BW] = 16'h3C5A;
        req_valid = 4'b1000; rsp_ready = 1'b0;
        @(negedge clk);
        g = exp_grant(req_valid);
        n_checks++; if (req_ready !== 4'b1000) $display("FAIL bp_grant: got %b expected 1000", req_ready); else n_pass++;
        sb_q.push_back(make_exp(g)); m_rr = (g + 1) % N;
        tick();
        req_a[0 +: AW] = 16'h4321; req_b[0 +: BW] = 16'hF00D; req_valid = 4'b0001;
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL bp_exec_ready: got %b expected 0000", req_ready); else n_pass++;
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            e = sb_q[0];
            n_checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b expected 1", c, rsp_valid); else n_pass++;
            n_checks++; if (rsp_id !== e.id) $display("FAIL bp_hold_id[%0d]: got %0d expected %0d", c, rsp_id, e.id); else n_pass++;
            n_checks++; if (rsp_data !== e.data) $display("FAIL bp_hold_data[%0d]: got %h expected %h", c, rsp_data, e.data); else n_pass++;
            n_checks++; if (req_ready !== 4'b0000) $display("FAIL bp_hold_ready[%0d]: got %b expected 0000", c, req_ready); else n_pass++;
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        e = sb_q.pop_front();
        n_checks++; if (rsp_data !== e.data) $display("FAIL bp_release_data: got %h expected %h", rsp_data, e.data); else n_pass++;
        g = exp_grant(req_valid);
        n_checks++; if (req_ready !== 4'(1 << g)) $display("FAIL bp_release_grant: got %b expected %b", req_ready, 4'(1 << g)); else n_pass++;
        sb_q.push_back(make_exp(g)); m_rr = (g + 1) % N;
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        e = sb_q.pop_front();
        n_checks++; if (rsp_id !== e.id) $display("FAIL bp_next_id: got %0d expected %0d", rsp_id, e.id); else n_pass++;
        n_checks++; if (rsp_data !== e.data) $display("FAIL bp_next_data: got %h expected %h", rsp_data, e.data); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        int g;
        req_a[1*AW +: AW] = 16'h7777; req_b[1*BW +: BW] = 16'h1111;
        req_valid = 4'b0010; rsp_ready = 1'b1;
        @(negedge clk);
        g = exp_grant(req_valid);
        n_checks++; if (req_ready !== 4'(1 << g)) $display("FAIL rmid_grant: got %b expected %b", req_ready, 4'(1 << g)); else n_pass++;
        sb_q.push_back(make_exp(g));
        tick();
        arst = 1'b1;
        #1;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rmid_valid: got %b expected 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_id !== 2'd0) $display("FAIL rmid_id: got %0d expected 0", rsp_id); else n_pass++;
        n_checks++; if (rsp_data !== 32'h0) $display("FAIL rmid_data: got %h expected 00000000", rsp_data); else n_pass++;
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL rmid_ready: got %b expected 0000", req_ready); else n_pass++;
        sb_q.delete(); m_rr = 0;
        @(posedge clk);
        #1;
        arst = 1'b0; req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rmid_stale[%0d]: got %b expected 0", c, rsp_valid); else n_pass++;
            tick();
        end
    endtask

`ifdef MUL_ARB_PERF_CNT_EN
    task automatic test_perf();
        exp_t e; int g;
        arst = 1'b1; #2; arst = 1'b0; m_rr = 0; sb_q.delete();
        tick();
        n_checks++; if (perf_busy_cnt !== 32'd0) $display("FAIL perf_start: got %0d expected 0", perf_busy_cnt); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            req_a[i*AW +: AW] = 16'($urandom); req_b[i*BW +: BW] = 16'($urandom);
        end
        req_valid = 4'b0111; rsp_ready = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c >= 2 && (c % 2) == 0) begin
                e = sb_q.pop_front();
                n_checks++; if (rsp_data !== e.data) $display("FAIL perf_data[%0d]: got %h expected %h", c, rsp_data, e.data); else n_pass++;
            end
            if ((c % 2) == 0 && c <= 4) begin
                g = exp_grant(req_valid);
                n_checks++; if (req_ready !== 4'(1 << g)) $display("FAIL perf_grant[%0d]: got %b expected %b", c, req_ready, 4'(1 << g)); else n_pass++;
                sb_q.push_back(make_exp(g)); m_rr = (g + 1) % N;
            end
            tick();
            if (c == 4) req_valid = '0;
        end
        @(negedge clk);
        n_checks++; if (perf_busy_cnt !== 32'd6) $display("FAIL perf_count: got %0d expected 6", perf_busy_cnt); else n_pass++;
        tick();
        tick();
        @(negedge clk);
        n_checks++; if (perf_busy_cnt !== 32'd6) $display("FAIL perf_idle_hold: got %0d expected 6", perf_busy_cnt); else n_pass++;
        tick();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_arith();
        test_fairness();
        test_backpressure();
        test_reset_mid();
`ifdef MUL_ARB_PERF_CNT_EN
        test_perf();
`endif
        n_checks++; if (sb_q.size() != 0) $display("FAIL sb_empty: got %0d pending expected 0", sb_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
